// File: rtl/rx_field_capture.sv
`default_nettype none
// ============================================================================
// Module      : rx_field_capture
// Description : Captures one packet field (SYNC, PID, CRC5, CRC16 or DATA)
//               from a decoded serial bit stream, LSB first. Stuffed bits are
//               dropped. DATA bytes are packed into rcv_data with byte-count,
//               overflow and fragment tracking.
// Ports       : clk, rst (async, active high)
//               start/field_sel   - begin capture of the selected field
//               bit_valid/stuff_bit/d_orig - serial bit input and qualifiers
//               eop               - terminates a DATA field
//               abort             - cancels the capture in progress
//               busy, field_done, byte_done, byte_cnt, overflow, frag_err
//               rcv_sync, rcv_pid, rcv_crc5, rcv_crc16, rcv_data - captures
// Revision    : 1.0 - initial release
// ============================================================================
module rx_field_capture #(
    parameter int DATA_BYTES = 8,
    parameter int CNT_W      = $clog2(DATA_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [2:0]              field_sel,
    input  logic                    bit_valid,
    input  logic                    stuff_bit,
    input  logic                    d_orig,
    input  logic                    eop,
    input  logic                    abort,
    output logic                    busy,
    output logic                    field_done,
    output logic                    byte_done,
    output logic [CNT_W-1:0]        byte_cnt,
    output logic                    overflow,
    output logic                    frag_err,
    output logic [7:0]              rcv_sync,
    output logic [7:0]              rcv_pid,
    output logic [4:0]              rcv_crc5,
    output logic [15:0]             rcv_crc16,
    output logic [8*DATA_BYTES-1:0] rcv_data
);

    localparam logic [2:0] c_SEL_SYNC  = 3'd0;
    localparam logic [2:0] c_SEL_PID   = 3'd1;
    localparam logic [2:0] c_SEL_CRC5  = 3'd2;
    localparam logic [2:0] c_SEL_CRC16 = 3'd3;
    localparam logic [2:0] c_SEL_DATA  = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [2:0]              r_sel;
    logic [4:0]              r_bit_cnt;
    logic [7:0]              r_byte;
    logic                    r_byte_done;
    logic [CNT_W-1:0]        r_byte_cnt;
    logic                    r_overflow;
    logic                    r_frag_err;
    logic [7:0]              r_sync;
    logic [7:0]              r_pid;
    logic [4:0]              r_crc5;
    logic [15:0]             r_crc16;
    logic [8*DATA_BYTES-1:0] r_data;

    logic                    w_start_ok;
    logic                    w_acc;
    logic                    w_is_data;
    logic [4:0]              w_width;
    logic [4:0]              w_cnt_inc;
    logic                    w_byte_full;
    logic [7:0]              w_byte_new;
    logic                    w_field_last;
    logic                    w_eop_end;
    logic [2:0]              w_bits_after;

    assign w_start_ok   = start & (field_sel <= c_SEL_DATA);
    assign w_acc        = (r_state == SHIFT) & bit_valid & ~stuff_bit & ~start & ~abort;
    assign w_is_data    = (r_sel == c_SEL_DATA);
    assign w_cnt_inc    = r_bit_cnt + 5'd1;
    assign w_byte_new   = {d_orig, r_byte[7:1]};
    assign w_byte_full  = w_is_data & w_acc & (r_bit_cnt[2:0] == 3'd7);
    assign w_field_last = ~w_is_data & w_acc & (w_cnt_inc == w_width);
    assign w_eop_end    = (r_state == SHIFT) & w_is_data & eop & ~start & ~abort;
    // Bit position inside the current DATA byte once this cycle's bit (if
    // any) is taken; the 3-bit wrap makes a just-completed byte read as 0.
    assign w_bits_after = w_acc ? w_cnt_inc[2:0] : r_bit_cnt[2:0];

    always_comb begin
        w_width = 5'd8;
        case (r_sel)
            c_SEL_CRC5:  w_width = 5'd5;
            c_SEL_CRC16: w_width = 5'd16;
            default:     w_width = 5'd8;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_start_ok) begin
            w_state_nxt = SHIFT;
        end else begin
            case (r_state)
                SHIFT: begin
                    if (abort) begin
                        w_state_nxt = IDLE;
                    end else if (w_field_last || w_eop_end) begin
                        w_state_nxt = DONE;
                    end
                end
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel       <= c_SEL_SYNC;
            r_bit_cnt   <= 5'd0;
            r_byte      <= 8'd0;
            r_byte_done <= 1'b0;
            r_byte_cnt  <= '0;
            r_overflow  <= 1'b0;
            r_frag_err  <= 1'b0;
            r_sync      <= 8'd0;
            r_pid       <= 8'd0;
            r_crc5      <= 5'd0;
            r_crc16     <= 16'd0;
            r_data      <= '0;
        end else begin
            r_byte_done <= 1'b0;
            if (w_start_ok) begin
                r_sel     <= field_sel;
                r_bit_cnt <= 5'd0;
                case (field_sel)
                    c_SEL_SYNC:  r_sync  <= 8'd0;
                    c_SEL_PID:   r_pid   <= 8'd0;
                    c_SEL_CRC5:  r_crc5  <= 5'd0;
                    c_SEL_CRC16: r_crc16 <= 16'd0;
                    default: begin
                        r_byte     <= 8'd0;
                        r_byte_cnt <= '0;
                        r_data     <= '0;
                        r_overflow <= 1'b0;
                        r_frag_err <= 1'b0;
                    end
                endcase
            end else if (w_acc) begin
                if (w_is_data) begin
                    // DATA only needs the position within the byte.
                    r_bit_cnt <= {2'b00, w_cnt_inc[2:0]};
                    r_byte    <= w_byte_new;
                    if (w_byte_full) begin
                        r_byte_done <= 1'b1;
                        if (r_byte_cnt < CNT_W'(DATA_BYTES)) begin
                            for (int k = 0; k < DATA_BYTES; k++) begin
                                if (r_byte_cnt == CNT_W'(k)) begin
                                    r_data[8*k +: 8] <= w_byte_new;
                                end
                            end
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                end else begin
                    r_bit_cnt <= w_cnt_inc;
                    case (r_sel)
                        c_SEL_SYNC:  r_sync  <= {d_orig, r_sync[7:1]};
                        c_SEL_PID:   r_pid   <= {d_orig, r_pid[7:1]};
                        c_SEL_CRC5:  r_crc5  <= {d_orig, r_crc5[4:1]};
                        default:     r_crc16 <= {d_orig, r_crc16[15:1]};
                    endcase
                end
            end
            // A partial byte at end of packet is dropped, only flagged.
            if (w_eop_end && (w_bits_after != 3'd0)) begin
                r_frag_err <= 1'b1;
            end
        end
    end

    assign busy       = (r_state == SHIFT);
    assign field_done = (r_state == DONE);
    assign byte_done  = r_byte_done;
    assign byte_cnt   = r_byte_cnt;
    assign overflow   = r_overflow;
    assign frag_err   = r_frag_err;
    assign rcv_sync   = r_sync;
    assign rcv_pid    = r_pid;
    assign rcv_crc5   = r_crc5;
    assign rcv_crc16  = r_crc16;
    assign rcv_data   = r_data;

endmodule
`default_nettype wire

// File: tb/tb_rx_field_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_field_capture
// Description : Directed self-checking bench for rx_field_capture with
//               DATA_BYTES=2 (so overflow is reachable with three bytes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_field_capture;

    localparam int DATA_BYTES = 2;
    localparam int CNT_W      = $clog2(DATA_BYTES + 1);

    logic                    clk;
    logic                    rst;
    logic                    start;
    logic [2:0]              field_sel;
    logic                    bit_valid;
    logic                    stuff_bit;
    logic                    d_orig;
    logic                    eop;
    logic                    abort;
    logic                    busy;
    logic                    field_done;
    logic                    byte_done;
    logic [CNT_W-1:0]        byte_cnt;
    logic                    overflow;
    logic                    frag_err;
    logic [7:0]              rcv_sync;
    logic [7:0]              rcv_pid;
    logic [4:0]              rcv_crc5;
    logic [15:0]             rcv_crc16;
    logic [8*DATA_BYTES-1:0] rcv_data;

    int n_tests = 0;
    int n_fail  = 0;

    rx_field_capture #(
        .DATA_BYTES (DATA_BYTES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .field_sel  (field_sel),
        .bit_valid  (bit_valid),
        .stuff_bit  (stuff_bit),
        .d_orig     (d_orig),
        .eop        (eop),
        .abort      (abort),
        .busy       (busy),
        .field_done (field_done),
        .byte_done  (byte_done),
        .byte_cnt   (byte_cnt),
        .overflow   (overflow),
        .frag_err   (frag_err),
        .rcv_sync   (rcv_sync),
        .rcv_pid    (rcv_pid),
        .rcv_crc5   (rcv_crc5),
        .rcv_crc16  (rcv_crc16),
        .rcv_data   (rcv_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Advance one rising edge, then settle 1 time unit for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2:0] sel);
        start     = 1'b1;
        field_sel = sel;
        step();
        start     = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic stf);
        bit_valid = 1'b1;
        d_orig    = b;
        stuff_bit = stf;
        step();
        bit_valid = 1'b0;
        stuff_bit = 1'b0;
        d_orig    = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if ({busy, field_done, byte_done, overflow, frag_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000", {busy, field_done, byte_done, overflow, frag_err});
        end
        n_tests++;
        if (byte_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_byte_cnt: got %0d want 0", byte_cnt);
        end
        n_tests++;
        if ({rcv_sync, rcv_pid, rcv_crc5, rcv_crc16, rcv_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_rcv: got %h want 0", {rcv_sync, rcv_pid, rcv_crc5, rcv_crc16, rcv_data});
        end
        step();
        step();
        rst = 1'b0;
        step();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_pid();
        logic [7:0] pat;
        pat = 8'h69;
        do_start(3'd1);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pid_busy: got %b want 1", busy);
        end
        for (int i = 0; i < 8; i++) begin
            send_bit(pat[i], 1'b0);
            if (i == 6) begin
                n_tests++;
                if (field_done !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL pid_early_done: got done=%b busy=%b want 0/1", field_done, busy);
                end
            end
        end
        n_tests++;
        if (field_done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL pid_done: got done=%b busy=%b want 1/0", field_done, busy);
        end
        n_tests++;
        if (rcv_pid !== 8'h69) begin
            n_fail++;
            $display("FAIL pid_value: got %h want 69", rcv_pid);
        end
        step();
        n_tests++;
        if (field_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL pid_idle: got done=%b busy=%b want 0/0", field_done, busy);
        end
    endtask

    task automatic test_crc5_stuff();
        logic [5:0] bits;
        bits = 6'b110011;  // sent from bit 0 upward: 1,1,0,0,1,1
        do_start(3'd2);
        for (int i = 0; i < 6; i++) begin
            send_bit(bits[i], i == 2);
        end
        n_tests++;
        if (field_done !== 1'b1) begin
            n_fail++;
            $display("FAIL crc5_done: got %b want 1", field_done);
        end
        n_tests++;
        if (rcv_crc5 !== 5'h1B) begin
            n_fail++;
            $display("FAIL crc5_value: got %h want 1b", rcv_crc5);
        end
        n_tests++;
        if (rcv_pid !== 8'h69 || rcv_sync !== 8'h00) begin
            n_fail++;
            $display("FAIL crc5_others: got pid=%h sync=%h want 69/00", rcv_pid, rcv_sync);
        end
        step();
    endtask

    task automatic test_data_overflow();
        logic [23:0] stream;
        int          n_bd;
        stream = 24'hFF3CA5;  // bytes A5, 3C, FF in order, each LSB first
        n_bd   = 0;
        do_start(3'd4);
        for (int i = 0; i < 24; i++) begin
            send_bit(stream[i], 1'b0);
            if (byte_done === 1'b1) n_bd++;
        end
        eop = 1'b1;
        step();
        eop = 1'b0;
        n_tests++;
        if (field_done !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_done: got %b want 1", field_done);
        end
        n_tests++;
        if (rcv_data !== 16'h3CA5) begin
            n_fail++;
            $display("FAIL ovf_data: got %h want 3ca5", rcv_data);
        end
        n_tests++;
        if (byte_cnt !== 2'd2 || overflow !== 1'b1 || frag_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_status: got cnt=%0d ovf=%b frag=%b want 2/1/0", byte_cnt, overflow, frag_err);
        end
        n_tests++;
        if (n_bd != 3) begin
            n_fail++;
            $display("FAIL ovf_byte_done: got %0d pulses want 3", n_bd);
        end
        step();
    endtask

    task automatic test_frag();
        logic [11:0] stream;
        stream = 12'hD5A;  // byte 5A then partial nibble 1,0,1,1
        do_start(3'd4);
        n_tests++;
        if (overflow !== 1'b0 || byte_cnt !== 2'd0 || rcv_data !== 16'h0) begin
            n_fail++;
            $display("FAIL frag_clear: got ovf=%b cnt=%0d data=%h want 0/0/0", overflow, byte_cnt, rcv_data);
        end
        for (int i = 0; i < 12; i++) begin
            send_bit(stream[i], 1'b0);
        end
        eop = 1'b1;
        step();
        eop = 1'b0;
        n_tests++;
        if (field_done !== 1'b1 || frag_err !== 1'b1) begin
            n_fail++;
            $display("FAIL frag_flags: got done=%b frag=%b want 1/1", field_done, frag_err);
        end
        n_tests++;
        if (byte_cnt !== 2'd1 || rcv_data !== 16'h005A) begin
            n_fail++;
            $display("FAIL frag_data: got cnt=%0d data=%h want 1/005a", byte_cnt, rcv_data);
        end
        step();
    endtask

    task automatic test_eop_same_cycle();
        logic [15:0] stream;
        stream = 16'h81C3;
        do_start(3'd4);
        n_tests++;
        if (frag_err !== 1'b0) begin
            n_fail++;
            $display("FAIL eop_frag_clear: got %b want 0", frag_err);
        end
        for (int i = 0; i < 15; i++) begin
            send_bit(stream[i], 1'b0);
        end
        eop = 1'b1;
        send_bit(stream[15], 1'b0);
        eop = 1'b0;
        n_tests++;
        if (field_done !== 1'b1 || byte_done !== 1'b1 || frag_err !== 1'b0) begin
            n_fail++;
            $display("FAIL eop_same_flags: got done=%b bd=%b frag=%b want 1/1/0", field_done, byte_done, frag_err);
        end
        n_tests++;
        if (byte_cnt !== 2'd2 || rcv_data !== 16'h81C3) begin
            n_fail++;
            $display("FAIL eop_same_data: got cnt=%0d data=%h want 2/81c3", byte_cnt, rcv_data);
        end
        step();
    endtask

    task automatic test_abort();
        do_start(3'd3);
        for (int i = 0; i < 7; i++) begin
            send_bit(1'b1, 1'b0);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || field_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: got busy=%b done=%b want 0/0", busy, field_done);
        end
        n_tests++;
        if (rcv_crc16 !== 16'hFE00) begin
            n_fail++;
            $display("FAIL abort_partial: got %h want fe00", rcv_crc16);
        end
        step();
        n_tests++;
        if (field_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %b want 0", field_done);
        end
        do_start(3'd3);
        n_tests++;
        if (rcv_crc16 !== 16'h0000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_restart: got crc16=%h busy=%b want 0000/1", rcv_crc16, busy);
        end
    endtask

    // Runs while the CRC16 capture from test_abort is still in SHIFT.
    task automatic test_start_priority();
        logic [7:0] pat;
        pat       = 8'h80;
        start     = 1'b1;
        field_sel = 3'd0;
        bit_valid = 1'b1;
        d_orig    = 1'b1;
        abort     = 1'b1;
        step();
        start     = 1'b0;
        bit_valid = 1'b0;
        d_orig    = 1'b0;
        abort     = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || rcv_sync !== 8'h00) begin
            n_fail++;
            $display("FAIL prio_start: got busy=%b sync=%h want 1/00", busy, rcv_sync);
        end
        for (int i = 0; i < 8; i++) begin
            send_bit(pat[i], 1'b0);
        end
        n_tests++;
        if (field_done !== 1'b1 || rcv_sync !== 8'h80 || rcv_crc16 !== 16'h0000) begin
            n_fail++;
            $display("FAIL prio_sync: got done=%b sync=%h crc16=%h want 1/80/0000", field_done, rcv_sync, rcv_crc16);
        end
        step();
    endtask

    task automatic test_rst_mid();
        do_start(3'd0);
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1, 1'b0);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({busy, field_done, byte_done, overflow, frag_err} !== 5'b0 || byte_cnt !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_flags: got %b cnt=%0d want 00000/0", {busy, field_done, byte_done, overflow, frag_err}, byte_cnt);
        end
        n_tests++;
        if ({rcv_sync, rcv_pid, rcv_crc5, rcv_crc16, rcv_data} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_rcv: got %h want 0", {rcv_sync, rcv_pid, rcv_crc5, rcv_crc16, rcv_data});
        end
        #3 rst = 1'b0;
        do_start(3'd6);
        n_tests++;
        if (busy !== 1'b0 || field_done !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_sel: got busy=%b done=%b want 0/0", busy, field_done);
        end
        do_start(3'd5);
        send_bit(1'b1, 1'b0);
        n_tests++;
        if (busy !== 1'b0 || rcv_sync !== 8'h00) begin
            n_fail++;
            $display("FAIL bad_sel5: got busy=%b sync=%h want 0/00", busy, rcv_sync);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        field_sel = 3'd0;
        bit_valid = 1'b0;
        stuff_bit = 1'b0;
        d_orig    = 1'b0;
        eop       = 1'b0;
        abort     = 1'b0;
        test_reset();
        test_pid();
        test_crc5_stuff();
        test_data_overflow();
        test_frag();
        test_eop_same_cycle();
        test_abort();
        test_start_priority();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rx_field_capture.md
RX_FIELD_CAPTURE -- requirements
Module: rx_field_capture

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 8, giving the maximum number of data-field bytes stored (1..64).
REQ-002 SHALL have parameter CNT_W, default $clog2(DATA_BYTES+1), giving the width of byte_cnt.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst, input, 1, the asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, which begins capture of the field selected by field_sel.
REQ-006 SHALL have port field_sel, input, 3, with encoding 0=SYNC, 1=PID, 2=CRC5, 3=CRC16, 4=DATA; values 5-7 are invalid.
REQ-007 SHALL have port bit_valid, input, 1, which qualifies d_orig for one cycle.
REQ-008 SHALL have port stuff_bit, input, 1, which marks the current valid bit as a stuffed bit to discard.
REQ-009 SHALL have port d_orig, input, 1, the decoded serial data bit.
REQ-010 SHALL have port eop, input, 1, the end-of-packet strobe that terminates a DATA field.
REQ-011 SHALL have port abort, input, 1, which cancels the capture in progress.
REQ-012 SHALL have port busy, output, 1, high while state is SHIFT.
REQ-013 SHALL have port field_done, output, 1, a one-cycle pulse on field completion.
REQ-014 SHALL have port byte_done, output, 1, a one-cycle pulse on each completed DATA byte.
REQ-015 SHALL have port byte_cnt, output, CNT_W, the number of DATA bytes stored.
REQ-016 SHALL have port overflow, output, 1, sticky; high when more than DATA_BYTES bytes have been received.
REQ-017 SHALL have port frag_err, output, 1, sticky; high when eop arrives with a partial DATA byte.
REQ-018 SHALL have ports rcv_sync (8), rcv_pid (8), rcv_crc5 (5), rcv_crc16 (16) and rcv_data (8*DATA_BYTES), all outputs holding the captured fields.

Function
REQ-019 SHALL implement the states IDLE, SHIFT and DONE.
REQ-020 SHALL define an accepted bit as state==SHIFT & bit_valid & ~stuff_bit & ~start & ~abort.
REQ-021 SHALL, for SYNC, PID, CRC5 and CRC16, shift each accepted bit into the register MSB and shift right, so that the first received bit lands in bit 0 after full width (LSB-first).
REQ-022 SHALL use field widths SYNC=8, PID=8, CRC5=5 and CRC16=16, tracked by an internal bit counter.
REQ-023 SHALL, for DATA, shift bits into an internal 8-bit byte register in the same LSB-first manner.
REQ-024 SHALL, for DATA, write each completed byte k to rcv_data[8k+7:8k] and increment byte_cnt.
REQ-025 SHALL assert byte_done in the cycle after the edge that samples the 8th bit of each DATA byte.
REQ-026 SHALL update only the register of the active field; all other rcv_* outputs hold their values.
REQ-027 SHALL, when start is asserted with a valid field_sel in any state: latch field_sel, clear the bit counter, clear the target register (for DATA also clear byte_cnt, rcv_data, overflow and frag_err), and enter SHIFT.
REQ-028 SHALL ignore start when field_sel is 5-7, leaving state unchanged.
REQ-029 SHALL give start priority over abort, bit_valid and eop in the same cycle; a bit presented in that cycle is not captured.
REQ-030 SHALL, on a fixed-width field, move SHIFT->DONE on the edge that samples the final accepted bit.
REQ-031 SHALL have the register value valid and field_done high in the following cycle (DONE).
REQ-032 SHALL, on DATA with eop in SHIFT, move SHIFT->DONE; if eop and an accepted bit occur in the same cycle, the bit is captured first.
REQ-033 SHALL set frag_err when eop arrives and the DATA bit count mod 8 != 0; the partial byte is discarded.
REQ-034 SHALL, once DATA_BYTES bytes are stored, discard further completed bytes, set overflow, and saturate byte_cnt at DATA_BYTES.
REQ-035 SHALL move DONE->IDLE after one cycle unless start is asserted.
REQ-036 SHALL, on abort in SHIFT, move to IDLE with no field_done and leave partial register contents held.
REQ-037 SHALL ignore bit_valid, eop and abort in IDLE and DONE.
REQ-038 SHALL not count stuffed bits in the bit counter.

Reset
REQ-039 SHALL, on rst high, asynchronously force state IDLE, every rcv_* output to 0, byte_cnt to 0, and busy, field_done, byte_done, overflow and frag_err to 0.
REQ-040 SHALL, on rst mid-capture, discard the capture; the first rising edge after rst deasserts is the first edge that acts on inputs.

Verification
REQ-041 SHALL cover: start PID, then bits 1,0,0,1,0,1,1,0 -> rcv_pid=8'h69, field_done one cycle after the 8th bit, busy low afterward.
REQ-042 SHALL cover: start CRC5, 6 valid bits with the 3rd flagged stuff_bit -> only 5 captured, rcv_crc5 excludes the stuffed bit, other rcv_* unchanged.
REQ-043 SHALL cover: DATA_BYTES=2, start DATA, 24 bits of bytes 8'hA5,8'h3C,8'hFF, then eop -> rcv_data=16'h3CA5, byte_cnt=2, overflow=1, three byte_done pulses.
REQ-044 SHALL cover: start DATA, 12 bits then eop -> byte_cnt=1, frag_err=1, field_done pulses.
REQ-045 SHALL cover: start CRC16, 7 bits, abort -> IDLE, no field_done; start CRC16 again -> rcv_crc16 cleared to 0.
REQ-046 SHALL cover: rst asserted mid-SHIFT of SYNC -> all outputs 0 immediately without a clock edge; start with field_sel=6 -> state remains IDLE.
